// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared constants for the RV32M multi-cycle execute unit:
//   - ALUSel codes for the M-extension operations (ALU_MUL, ALU_DIV, ALU_REM)
//   - FSM state encodings (MD_IDLE, MD_CALC, MD_FIN)
// No ports; imported by muldiv_unit and div_core.
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

    // ALUSel codes driven by the ALU control unit for the M-extension ops
    localparam logic [3:0] ALU_MUL = 4'd10;
    localparam logic [3:0] ALU_DIV = 4'd11;
    localparam logic [3:0] ALU_REM = 4'd12;

    // Sequencer state encodings
    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_CALC = 2'd1;
    localparam logic [1:0] MD_FIN  = 2'd2;

endpackage : muldiv_unit_pkg

// File: rtl/muldiv_unit_div_core.sv
// -----------------------------------------------------------------------------
// div_core
// Unsigned restoring divider datapath, one quotient bit per cycle, MSB first.
// Holds the iteration counter, the divisor register, the dividend/quotient
// shift register and the partial remainder. Sign handling and special cases
// live in the parent.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        capture dividend/divisor magnitudes and arm the counter
//   step        perform one restoring iteration (parent asserts in CALC)
//   dividend    unsigned dividend magnitude
//   divisor     unsigned divisor magnitude (never zero when iterated)
//   quo_step    quotient after the iteration currently being performed
//   rem_step    remainder after the iteration currently being performed
//   last        counter is 1: the iteration at this edge is the final one
// -----------------------------------------------------------------------------
module div_core
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo_step,
    output logic [WIDTH-1:0] rem_step,
    output logic             last
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;

    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH:0]   diff_s;

    // One restoring iteration: shift in the next dividend bit, trial-subtract.
    // The shifted partial remainder needs WIDTH+1 bits; the stored remainder
    // is always below the divisor so WIDTH bits suffice between iterations.
    always_comb begin
        rem_shift_s = {rem_q, quo_q[WIDTH-1]};
        diff_s      = rem_shift_s - {1'b0, dvs_q};
        if (diff_s[WIDTH] == 1'b0) begin
            rem_step = diff_s[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = rem_shift_s[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state for counter and operand registers
    always_comb begin
        cnt_d = cnt_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        if (load) begin
            cnt_d = CNT_FULL;
            quo_d = dividend;
            rem_d = {WIDTH{1'b0}};
            dvs_d = divisor;
        end else if (step) begin
            quo_d = quo_step;
            rem_d = rem_step;
            if (cnt_q != CNT_ZERO) begin
                cnt_d = cnt_q - CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign last = (cnt_q == CNT_ONE);

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_ZERO;
            quo_q <= {WIDTH{1'b0}};
            rem_q <= {WIDTH{1'b0}};
            dvs_q <= {WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

endmodule : div_core

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle RV32M execute unit (MUL low half, signed DIV, signed REM).
// Sequencer IDLE -> CALC (WIDTH iterations) -> FIN (done pulse). Division by
// zero and signed overflow are resolved on accept and go straight to FIN.
// Build option: define FAST_MUL_EN to use a combinational multiplier so MUL
// goes IDLE->FIN directly; otherwise MUL is an iterative shift-add.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       M-op valid from ID/EX; sampled in IDLE or FIN
//   alu_sel     ALUSel; only ALU_MUL/ALU_DIV/ALU_REM are accepted
//   op_a, op_b  rs1 / rs2 operands
//   flush       aborts an in-flight op; blocks acceptance of start
//   busy        high during CALC (pipeline stall)
//   done        one-cycle pulse in FIN
//   result      product low half / quotient / remainder, held until next done
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Two's-complement negate when neg is set
    function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
        if (neg) begin
            return ZERO - v;
        end else begin
            return v;
        end
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             is_rem_q, is_rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    logic             op_valid_s;
    logic             accept_s;
    logic             div_zero_s;
    logic             ovf_s;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic [WIDTH-1:0] quo_step_s;
    logic [WIDTH-1:0] rem_step_s;
    logic             core_last_s;
    logic             core_step_s;

`ifdef FAST_MUL_EN
    logic [WIDTH-1:0] fast_prod_s;
    assign fast_prod_s = op_a * op_b;
`else
    logic             is_mul_q, is_mul_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_step_s;
    assign acc_step_s = acc_q + (mplier_q[0] ? mcand_q : ZERO);
`endif

    // Accept decode and operand conditioning
    always_comb begin
        op_valid_s = (alu_sel == ALU_MUL) || (alu_sel == ALU_DIV) || (alu_sel == ALU_REM);
        accept_s   = start && op_valid_s && !flush &&
                     ((state_q == MD_IDLE) || (state_q == MD_FIN));
        div_zero_s = (op_b == ZERO);
        ovf_s      = (op_a == MOST_NEG) && (op_b == ALL_ONES);
        mag_a_s    = cond_neg(op_a[WIDTH-1], op_a);
        mag_b_s    = cond_neg(op_b[WIDTH-1], op_b);
        core_step_s = (state_q == MD_CALC);
    end

    div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept_s),
        .step     (core_step_s),
        .dividend (mag_a_s),
        .divisor  (mag_b_s),
        .quo_step (quo_step_s),
        .rem_step (rem_step_s),
        .last     (core_last_s)
    );

    // Sequencer, result capture and multiplier iteration
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`ifndef FAST_MUL_EN
        is_mul_d  = is_mul_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
`endif
        case (state_q)
            MD_IDLE, MD_FIN: begin
                if (accept_s) begin
                    is_rem_d  = (alu_sel == ALU_REM);
                    neg_quo_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                    neg_rem_d = op_a[WIDTH-1];
`ifndef FAST_MUL_EN
                    is_mul_d  = (alu_sel == ALU_MUL);
`endif
                    if (alu_sel == ALU_MUL) begin
`ifdef FAST_MUL_EN
                        result_d = fast_prod_s;
                        state_d  = MD_FIN;
`else
                        acc_d    = ZERO;
                        mcand_d  = op_a;
                        mplier_d = op_b;
                        state_d  = MD_CALC;
`endif
                    end else if (div_zero_s) begin
                        result_d = (alu_sel == ALU_REM) ? op_a : ALL_ONES;
                        state_d  = MD_FIN;
                    end else if (ovf_s) begin
                        result_d = (alu_sel == ALU_REM) ? ZERO : op_a;
                        state_d  = MD_FIN;
                    end else begin
                        state_d  = MD_CALC;
                    end
                end else begin
                    // Invalid sel or no start: IDLE holds, FIN always retires
                    state_d = MD_IDLE;
                end
            end
            MD_CALC: begin
`ifndef FAST_MUL_EN
                acc_d    = acc_step_s;
                mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
`endif
                if (flush) begin
                    state_d = MD_IDLE;
                end else if (core_last_s) begin
                    // Final iteration happens at this edge, so use step values
                    state_d = MD_FIN;
`ifndef FAST_MUL_EN
                    if (is_mul_q) begin
                        result_d = acc_step_s;
                    end else
`endif
                    if (is_rem_q) begin
                        result_d = cond_neg(neg_rem_q, rem_step_s);
                    end else begin
                        result_d = cond_neg(neg_quo_q, quo_step_s);
                    end
                end else begin
                    state_d = MD_CALC;
                end
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
        busy_d = (state_d == MD_CALC);
        done_d = (state_d == MD_FIN);
    end

    // Control and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MD_IDLE;
            result_q  <= ZERO;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

`ifndef FAST_MUL_EN
    // Shift-add multiplier registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_mul_q <= 1'b0;
            acc_q    <= ZERO;
            mcand_q  <= ZERO;
            mplier_q <= ZERO;
        end else begin
            is_mul_q <= is_mul_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule : muldiv_unit

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed scenarios with fixed expected values, then randomized back-to-back
// operations checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [3:0]   alu_sel;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int n_vec;
    int n_err;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .alu_sel (alu_sel),
        .op_a    (op_a),
        .op_b    (op_b),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V semantics from plain signed arithmetic
    function automatic logic [31:0] ref_result(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (sel == ALU_MUL) begin
            r = a * b;
        end else if (b == 32'd0) begin
            r = (sel == ALU_DIV) ? 32'hFFFF_FFFF : a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = (sel == ALU_DIV) ? a : 32'd0;
        end else if (sel == ALU_DIV) begin
            r = $signed(a) / $signed(b);
        end else begin
            r = $signed(a) % $signed(b);
        end
        return r;
    endfunction

    function automatic int ref_latency(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        if (sel == ALU_MUL) begin
`ifdef FAST_MUL_EN
            return 1;
`else
            return W + 1;
`endif
        end
        if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return W + 1;
    endfunction

    // Called at posedge+1: presents an op and follows it until done or budget.
    task automatic do_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input int inject_at, input int flush_at,
                         output int done_cyc, output int busy_cnt);
        alu_sel = sel;
        op_a    = a;
        op_b    = b;
        start   = 1'b1;
        flush   = 1'b0;
        done_cyc = 0;
        busy_cnt = 0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            start = (cyc == inject_at);
            if (cyc == inject_at) alu_sel = ALU_MUL;
            flush = (cyc == flush_at);
            op_a  = $urandom;
            op_b  = $urandom;
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        start = 1'b0;
        flush = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [3:0] sel, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input int inject_at);
        int dc;
        int bc;
        int lat;
        lat = ref_latency(sel, a, b);
        do_op(sel, a, b, inject_at, 0, dc, bc);
        check_value({tag, "_result"}, result, exp);
        check_value({tag, "_done_cycle"}, dc, lat);
        check_value({tag, "_busy_cycles"}, bc, lat - 1);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            4: return 32'd0 - $urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dc;
        int bc;
        logic [3:0] sel;
        logic [31:0] a;
        logic [31:0] b;
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        alu_sel = 4'd0;
        op_a    = 32'd0;
        op_b    = 32'd0;

        #12;
        check_value("reset_busy", {31'd0, busy}, 32'd0);
        check_value("reset_done", {31'd0, done}, 32'd0);
        check_value("reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed scenarios with spec-given results
        run_check("mul_7_m3",   ALU_MUL, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        run_check("div_m7_2",   ALU_DIV, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0);
        run_check("rem_m7_2",   ALU_REM, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0);
        run_check("div_100_7",  ALU_DIV, 32'd100,        32'd7,         32'd14,        0);
        run_check("rem_100_m7", ALU_REM, 32'd100,        32'hFFFF_FFF9, 32'd2,         0);
        run_check("div_5_0",    ALU_DIV, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
        run_check("rem_5_0",    ALU_REM, 32'd5,          32'd0,         32'd5,         0);
        run_check("div_ovf",    ALU_DIV, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_check("rem_ovf",    ALU_REM, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0);

        // Back-to-back: second DIV issued in FIN of the first; a stray start mid-CALC
        run_check("b2b_first",  ALU_DIV, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 5);
        run_check("b2b_second", ALU_DIV, 32'd100,        32'd7,         32'd14,        0);

        // Flush at cycle 10 of a DIV: no done, result retained
        do_op(ALU_DIV, 32'd1000, 32'd3, 0, 10, dc, bc);
        check_value("flush_no_done", dc, 32'd0);
        check_value("flush_busy_cycles", bc, 32'd10);
        check_value("flush_result_held", result, 32'd14);
        run_check("mul_3_4", ALU_MUL, 32'd3, 32'd4, 32'd12, 0);

        // Start with a non-M ALUSel is ignored
        alu_sel = 4'd0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_value("bad_sel_busy", {31'd0, busy}, 32'd0);
        check_value("bad_sel_done", {31'd0, done}, 32'd0);

        // Asynchronous reset mid-MUL
        alu_sel = ALU_MUL;
        op_a    = 32'd5;
        op_b    = 32'd6;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_value("async_rst_busy", {31'd0, busy}, 32'd0);
        check_value("async_rst_done", {31'd0, done}, 32'd0);
        check_value("async_rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_check("div_9_3", ALU_DIV, 32'd9, 32'd3, 32'd3, 0);

        // Randomized back-to-back operations against the reference model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: sel = ALU_MUL;
                1: sel = ALU_DIV;
                default: sel = ALU_REM;
            endcase
            a = pick_operand();
            b = pick_operand();
            run_check("rand", sel, a, b, ref_result(sel, a, b), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_muldiv_unit
